// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR post-processing blocks.
// Holds the divider width, its counter width and the divider FSM state type.
package fir_pkg;

    localparam int unsigned DIV_WIDTH = 16;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } div_state_t;

endpackage

// File: rtl/sub_stage_16bit.sv
// Combinational (WIDTH+1)-bit ripple-borrow subtractor: diff = minuend - subtrahend.
// The borrow output is set when subtrahend > minuend.
module sub_stage_16bit
    import fir_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0] minuend,
    input  logic [WIDTH:0] subtrahend,
    output logic [WIDTH:0] diff,
    output logic           borrow
);

    logic [WIDTH+1:0] bw;

    assign bw[0] = 1'b0;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_bit
        assign diff[i]  = minuend[i] ^ subtrahend[i] ^ bw[i];
        assign bw[i+1]  = (~minuend[i] & subtrahend[i]) |
                          (~(minuend[i] ^ subtrahend[i]) & bw[i]);
    end

    assign borrow = bw[WIDTH+1];

endmodule

// File: rtl/seq_divider_16bit.sv
// Multi-cycle restoring divider, one subtract/restore step per clock, valid/ready on both sides.
// Define SEQ_DIV_SIGNED_EN for two's-complement operands (magnitudes divided, signs fixed on exit).
module seq_divider_16bit
    import fir_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic             dbz;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] q_res;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic             fits;

    assign shifted = {rem, quo[WIDTH-1]};

    sub_stage_16bit #(
        .WIDTH (WIDTH)
    ) u_sub (
        .minuend    (shifted),
        .subtrahend ({1'b0, dvs}),
        .diff       (diff),
        .borrow     (borrow)
    );

    // rem < dvs on entry, so a non-borrowing trial always has a clear top bit.
    assign fits = ~borrow & ~diff[WIDTH];

`ifdef SEQ_DIV_SIGNED_EN
    logic q_neg;
    logic r_neg;

    assign dvd_mag = dividend[WIDTH-1] ? ({WIDTH{1'b0}} - dividend) : dividend;
    assign dvs_mag = divisor[WIDTH-1]  ? ({WIDTH{1'b0}} - divisor)  : divisor;

    // Zero divisor: quo still holds the dividend magnitude, re-signed for the remainder.
    assign q_res = dbz ? {WIDTH{1'b1}} : (q_neg ? ({WIDTH{1'b0}} - quo) : quo);
    assign r_res = dbz ? (r_neg ? ({WIDTH{1'b0}} - quo) : quo)
                       : (r_neg ? ({WIDTH{1'b0}} - rem) : rem);
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
    assign q_res   = dbz ? {WIDTH{1'b1}} : quo;
    assign r_res   = dbz ? quo : rem;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            dvs         <= '0;
            dbz         <= 1'b0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        rem      <= '0;
                        quo      <= dvd_mag;
                        dvs      <= dvs_mag;
                        cnt      <= CNT_W'(WIDTH - 1);
                        dbz      <= (divisor == '0);
                        state    <= (divisor == '0) ? DONE : CALC;
`ifdef SEQ_DIV_SIGNED_EN
                        q_neg    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_neg    <= dividend[WIDTH-1];
`endif
                    end
                end
                CALC: begin
                    rem <= fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    quo <= {quo[WIDTH-2:0], fits};
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle registers the result; later cycles wait for the consumer.
                    if (!out_valid) begin
                        quotient    <= q_res;
                        remainder   <= r_res;
                        div_by_zero <= dbz;
                        out_valid   <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider_16bit.sv
// Directed self-checking bench for seq_divider_16bit; expected values are hand-computed.
// Signed vectors are selected when SEQ_DIV_SIGNED_EN is defined.
module tb_seq_divider_16bit;

    localparam int MAX_WAIT = 64;
    localparam int NVEC     = 6;

`ifdef SEQ_DIV_SIGNED_EN
    // {dividend, divisor, quotient, remainder}
    localparam logic [15:0] VEC [NVEC][4] = '{
        '{16'd100,   16'd7,     16'd14,    16'd2},
        '{16'hFFFF,  16'd1,     16'hFFFF,  16'd0},
        '{16'd5,     16'd9,     16'd0,     16'd5},
        '{16'hFFF9,  16'd2,     16'hFFFD,  16'hFFFF},
        '{16'd7,     16'hFFFE,  16'hFFFD,  16'd1},
        '{16'h8000,  16'hFFFF,  16'h8000,  16'd0}
    };
`else
    localparam logic [15:0] VEC [NVEC][4] = '{
        '{16'd100,   16'd7,     16'd14,    16'd2},
        '{16'hFFFF,  16'd1,     16'hFFFF,  16'd0},
        '{16'd5,     16'd9,     16'd0,     16'd5},
        '{16'hABCD,  16'h0123,  16'd151,   16'd40},
        '{16'h8000,  16'hFFFF,  16'd0,     16'h8000},
        '{16'd65535, 16'd256,   16'd255,   16'd255}
    };
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_divider_16bit #(
        .WIDTH (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present operands for one accept edge, then scramble the inputs.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b);
        int w = 0;
        while (!in_ready && w < MAX_WAIT) begin
            step(1);
            w++;
        end
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        step(1);
        in_valid = 1'b0;
        dividend = 16'hDEAD;
        divisor  = 16'h0BAD;
    endtask

    // Edges counted after the accept edge until out_valid is seen.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < MAX_WAIT) begin
            step(1);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(2);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 16'd0 ||
            remainder !== 16'd0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b q=%h r=%h dbz=%b, required 1 0 0000 0000 0",
                     in_ready, out_valid, quotient, remainder, div_by_zero);
        end
        rst_n = 1'b1;
        step(1);
    endtask

    task automatic test_vectors();
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            start_op(VEC[i][0], VEC[i][1]);
            wait_result(lat);
            checks++;
            if (lat !== 17) begin
                errors++;
                $display("FAIL vec%0d_latency: got %0d edges, required 17", i, lat);
            end
            checks++;
            if (quotient !== VEC[i][2] || remainder !== VEC[i][3] || div_by_zero !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d_result: %h/%h gave q=%h r=%h dbz=%b, required q=%h r=%h dbz=0",
                         i, VEC[i][0], VEC[i][1], quotient, remainder, div_by_zero,
                         VEC[i][2], VEC[i][3]);
            end
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d_busy: in_ready=%b while result pending, required 0",
                         i, in_ready);
            end
            step(1);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL vec%0d_release: vld=%b rdy=%b, required 0 1",
                         i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_div_by_zero();
        int lat;
        out_ready = 1'b1;
        start_op(16'd1234, 16'd0);
        wait_result(lat);
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL dbz_latency: got %0d edges, required 1", lat);
        end
        checks++;
        if (quotient !== 16'hFFFF || remainder !== 16'd1234 || div_by_zero !== 1'b1) begin
            errors++;
            $display("FAIL dbz_result: q=%h r=%0d dbz=%b, required q=ffff r=1234 dbz=1",
                     quotient, remainder, div_by_zero);
        end
        step(1);
    endtask

    task automatic test_stall();
        int lat;
        out_ready = 1'b0;
        start_op(16'd50, 16'd5);
        wait_result(lat);
        checks++;
        if (lat !== 17) begin
            errors++;
            $display("FAIL stall_latency: got %0d edges, required 17", lat);
        end
        for (int i = 0; i < 10; i++) begin
            // A stray request mid-stall must not be captured.
            in_valid = (i == 3);
            dividend = 16'd60;
            divisor  = 16'd6;
            step(1);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 16'd10 ||
                remainder !== 16'd0 || div_by_zero !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: vld=%b rdy=%b q=%0d r=%0d dbz=%b, required 1 0 10 0 0",
                         i, out_valid, in_ready, quotient, remainder, div_by_zero);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step(1);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: vld=%b rdy=%b, required 0 1", out_valid, in_ready);
        end
        step(20);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_ignored: vld=%b rdy=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_midcalc();
        int lat;
        out_ready = 1'b1;
        start_op(16'd1000, 16'd3);
        step(7);
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 16'd0 ||
            remainder !== 16'd0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL midcalc_reset: rdy=%b vld=%b q=%h r=%h dbz=%b, required 1 0 0000 0000 0",
                     in_ready, out_valid, quotient, remainder, div_by_zero);
        end
        step(2);
        rst_n = 1'b1;
        step(1);
        start_op(16'd9, 16'd3);
        wait_result(lat);
        checks++;
        if (lat !== 17 || quotient !== 16'd3 || remainder !== 16'd0) begin
            errors++;
            $display("FAIL post_reset: lat=%0d q=%0d r=%0d, required lat=17 q=3 r=0",
                     lat, quotient, remainder);
        end
        step(1);
    endtask

    task automatic test_back_to_back();
        int lat;
        out_ready = 1'b1;
        start_op(16'd200, 16'd13);
        wait_result(lat);
        checks++;
        if (lat !== 17 || quotient !== 16'd15 || remainder !== 16'd5 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: lat=%0d q=%0d r=%0d dbz=%b, required 17 15 5 0",
                     lat, quotient, remainder, div_by_zero);
        end
        start_op(16'd32767, 16'd256);
        wait_result(lat);
        checks++;
        if (lat !== 17 || quotient !== 16'd127 || remainder !== 16'd255) begin
            errors++;
            $display("FAIL b2b_second: lat=%0d q=%0d r=%0d, required 17 127 255",
                     lat, quotient, remainder);
        end
        step(1);
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_div_by_zero();
        test_stall();
        test_reset_midcalc();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
